// File: rtl/vga3_fb_cmd_if.sv
`default_nettype none
// ============================================================================
// Module      : vga3_fb_cmd_if
// Description : Instruction handshake and framebuffer write port bundle for
//               the VGA3 command engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga3_fb_cmd_if #(
    parameter int ADDR_SIZE  = 15,
    parameter int COLOR_BITS = 4
) ();
    logic [11:0]           inst;
    logic                  inst_en;
    logic                  inst_ready;
    logic                  fb_we;
    logic [ADDR_SIZE-1:0]  fb_addr;
    logic [COLOR_BITS-1:0] fb_data;
    logic                  error;

    // Instruction source / write-port consumer side
    modport master (
        output inst, inst_en,
        input  inst_ready, fb_we, fb_addr, fb_data, error
    );

    // Command engine side
    modport slave (
        input  inst, inst_en,
        output inst_ready, fb_we, fb_addr, fb_data, error
    );
endinterface
`default_nettype wire

// File: rtl/vga3_fb_cmd.sv
`default_nettype none
// ============================================================================
// Module      : vga3_fb_cmd
// Description : VGA3 framebuffer command engine. Decodes 12-bit instructions
//               (cursor loads, pixel writes with auto-increment, fill colour,
//               hardware FILL) into writes on a framebuffer write port.
// Revision    : 1.0 - initial release
// ============================================================================
module vga3_fb_cmd #(
    parameter int COLS       = 200,
    parameter int ROWS       = 150,
    parameter int COLOR_BITS = 4,
    parameter int ADDR_SIZE  = 15
) (
    input  logic         clock,
    input  logic         reset,
    vga3_fb_cmd_if.slave bus
);

    localparam logic [3:0] c_op_nop  = 4'd0;
    localparam logic [3:0] c_op_ldr  = 4'd1;
    localparam logic [3:0] c_op_ldc  = 4'd2;
    localparam logic [3:0] c_op_ldd  = 4'd3;
    localparam logic [3:0] c_op_ldi  = 4'd4;
    localparam logic [3:0] c_op_ldk  = 4'd5;
    localparam logic [3:0] c_op_fill = 4'd6;

    // Limits widened to 9 bits so that a geometry of 256 compares correctly
    // against an 8-bit immediate.
    localparam logic [8:0]           c_rows_lim  = 9'(ROWS);
    localparam logic [8:0]           c_cols_lim  = 9'(COLS);
    localparam logic [7:0]           c_last_row  = 8'(ROWS - 1);
    localparam logic [7:0]           c_last_col  = 8'(COLS - 1);
    localparam logic [ADDR_SIZE-1:0] c_last_addr = ADDR_SIZE'(ROWS * COLS - 1);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_READY = 2'd1,
        S_FILL  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                r_state;
    logic [7:0]            r_row;
    logic [7:0]            r_col;
    logic [COLOR_BITS-1:0] r_fill_color;
    logic [ADDR_SIZE-1:0]  r_fill_cnt;
    logic                  r_inst_ready;
    logic                  r_fb_we;
    logic [ADDR_SIZE-1:0]  r_fb_addr;
    logic [COLOR_BITS-1:0] r_fb_data;
    logic                  r_error;

    logic [3:0]            w_opcode;
    logic [7:0]            w_imm;
    logic [COLOR_BITS-1:0] w_imm_color;
    logic                  w_accept;
    logic                  w_bad;
    logic [ADDR_SIZE-1:0]  w_cur_addr;

    assign w_opcode    = bus.inst[11:8];
    assign w_imm       = bus.inst[7:0];
    assign w_imm_color = w_imm[COLOR_BITS-1:0];
    // inst_ready is high exactly when the state is READY
    assign w_accept    = bus.inst_en & r_inst_ready;
    assign w_cur_addr  = ADDR_SIZE'(r_row) * ADDR_SIZE'(COLS) + ADDR_SIZE'(r_col);

    // An accepted instruction is illegal if it is an unknown opcode or a
    // cursor load outside the framebuffer geometry.
    assign w_bad = w_accept &
                   ((w_opcode > c_op_fill) |
                    ((w_opcode == c_op_ldr) & ({1'b0, w_imm} >= c_rows_lim)) |
                    ((w_opcode == c_op_ldc) & ({1'b0, w_imm} >= c_cols_lim)));

    // Control FSM with cursor, fill engine and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_RESET;
            r_row        <= 8'd0;
            r_col        <= 8'd0;
            r_fill_color <= '0;
            r_fill_cnt   <= '0;
            r_inst_ready <= 1'b0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_error      <= 1'b0;
        end else begin
            // Write strobe is a pulse unless re-armed below
            r_fb_we <= 1'b0;
            case (r_state)
                S_RESET: begin
                    r_state      <= S_READY;
                    r_inst_ready <= 1'b1;
                end

                S_READY: begin
                    if (w_bad) begin
                        r_state      <= S_ERROR;
                        r_error      <= 1'b1;
                        r_inst_ready <= 1'b0;
                        r_row        <= 8'd0;
                        r_col        <= 8'd0;
                        r_fill_color <= '0;
                    end else if (w_accept) begin
                        case (w_opcode)
                            c_op_nop: ;
                            c_op_ldr: r_row <= w_imm;
                            c_op_ldc: r_col <= w_imm;
                            c_op_ldd: begin
                                r_fb_we   <= 1'b1;
                                r_fb_addr <= w_cur_addr;
                                r_fb_data <= w_imm_color;
                            end
                            c_op_ldi: begin
                                r_fb_we   <= 1'b1;
                                r_fb_addr <= w_cur_addr;
                                r_fb_data <= w_imm_color;
                                // Row wrap at end of line, frame wrap at end of buffer
                                if (r_col == c_last_col) begin
                                    r_col <= 8'd0;
                                    r_row <= (r_row == c_last_row) ? 8'd0 : r_row + 8'd1;
                                end else begin
                                    r_col <= r_col + 8'd1;
                                end
                            end
                            c_op_ldk: r_fill_color <= w_imm_color;
                            c_op_fill: begin
                                // First fill write goes out in the cycle after accept
                                r_state      <= S_FILL;
                                r_inst_ready <= 1'b0;
                                r_fill_cnt   <= '0;
                                r_fb_we      <= 1'b1;
                                r_fb_addr    <= '0;
                                r_fb_data    <= r_fill_color;
                            end
                            default: ;
                        endcase
                    end
                end

                S_FILL: begin
                    if (r_fill_cnt == c_last_addr) begin
                        r_state      <= S_READY;
                        r_inst_ready <= 1'b1;
                        r_fill_cnt   <= '0;
                        r_row        <= 8'd0;
                        r_col        <= 8'd0;
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        r_fb_we    <= 1'b1;
                        r_fb_addr  <= r_fill_cnt + 1'b1;
                    end
                end

                S_ERROR: begin
                    r_error      <= 1'b1;
                    r_inst_ready <= 1'b0;
                end

                default: r_state <= S_RESET;
            endcase
        end
    end

    assign bus.inst_ready = r_inst_ready;
    assign bus.fb_we      = r_fb_we;
    assign bus.fb_addr    = r_fb_addr;
    assign bus.fb_data    = r_fb_data;
    assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vga3_fb_cmd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga3_fb_cmd
// Description : Self-checking bench for vga3_fb_cmd. Two instances cover the
//               default geometry (200x150x4) and a 64x48x8 variant. A
//               behavioural cursor model pushes expected writes into a
//               scoreboard queue; a monitor records observed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga3_fb_cmd;

    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] inst = '0;
    logic        inst_en = 1'b0;
    logic        sel = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model state for the configuration under test
    int         cols = 200;
    int         rows = 150;
    logic [7:0] cmask = 8'h0F;
    int         m_row, m_col;
    logic [7:0] m_fill;

    wr_t exp_q[$];
    wr_t obs_q[$];

    always #5 clock = ~clock;

    vga3_fb_cmd_if #(.ADDR_SIZE(15), .COLOR_BITS(4)) ifa ();
    vga3_fb_cmd_if #(.ADDR_SIZE(15), .COLOR_BITS(8)) ifb ();

    assign ifa.inst    = inst;
    assign ifa.inst_en = inst_en & ~sel;
    assign ifb.inst    = inst;
    assign ifb.inst_en = inst_en & sel;

    vga3_fb_cmd #(.COLS(200), .ROWS(150), .COLOR_BITS(4), .ADDR_SIZE(15)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    vga3_fb_cmd #(.COLS(64), .ROWS(48), .COLOR_BITS(8), .ADDR_SIZE(15)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    logic        obs_ready, obs_we, obs_err;
    logic [14:0] obs_addr;
    logic [7:0]  obs_data;

    // Outputs of the instance currently under test
    always_comb begin
        if (sel) begin
            obs_ready = ifb.inst_ready;
            obs_we    = ifb.fb_we;
            obs_addr  = ifb.fb_addr;
            obs_data  = ifb.fb_data;
            obs_err   = ifb.error;
        end else begin
            obs_ready = ifa.inst_ready;
            obs_we    = ifa.fb_we;
            obs_addr  = ifa.fb_addr;
            obs_data  = {4'h0, ifa.fb_data};
            obs_err   = ifa.error;
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Record every observed write with the cycle it appeared in
    always @(negedge clock) begin : mon
        wr_t w;
        if (obs_we === 1'b1) begin
            w.cyc  = cyc;
            w.addr = obs_addr;
            w.data = obs_data;
            obs_q.push_back(w);
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        inst_en = 1'b0;
        repeat (n) tick();
    endtask

    // Drive one instruction for one cycle and update the expected model
    task automatic send(input logic [3:0] op, input logic [7:0] imm);
        wr_t w;
        inst    = {op, imm};
        inst_en = 1'b1;
        tick();
        case (op)
            4'd1: m_row = int'(imm);
            4'd2: m_col = int'(imm);
            4'd3, 4'd4: begin
                w.cyc  = cyc;
                w.addr = 15'(m_row * cols + m_col);
                w.data = imm & cmask;
                exp_q.push_back(w);
                if (op == 4'd4) begin
                    if (m_col == cols - 1) begin
                        m_col = 0;
                        m_row = (m_row == rows - 1) ? 0 : m_row + 1;
                    end else begin
                        m_col = m_col + 1;
                    end
                end
            end
            4'd5: m_fill = imm & cmask;
            4'd6: begin
                for (int i = 0; i < rows * cols; i++) begin
                    w.cyc  = cyc + i;
                    w.addr = 15'(i);
                    w.data = m_fill;
                    exp_q.push_back(w);
                end
                m_row = 0;
                m_col = 0;
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        inst_en = 1'b0;
        reset   = 1'b1;
        m_row = 0; m_col = 0; m_fill = 8'h00;
        repeat (3) tick();
        n_checks++;
        if ({obs_ready, obs_we, obs_addr, obs_data, obs_err} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d data=%h err=%b, want all 0",
                     obs_ready, obs_we, obs_addr, obs_data, obs_err);
        end
        reset = 1'b0;
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b want 0", obs_ready);
        end
        tick();
        n_checks++;
        if (obs_ready !== 1'b1 || obs_we !== 1'b0 || obs_err !== 1'b0 ||
            obs_addr !== 15'd0 || obs_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ready_high: got ready=%b we=%b addr=%0d data=%h err=%b, want ready=1 rest 0",
                     obs_ready, obs_we, obs_addr, obs_data, obs_err);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_write();
        wr_t e, o;
        send(4'd1, 8'd2);
        send(4'd2, 8'd5);
        send(4'd3, 8'hDA);
        send(4'd3, 8'h5C);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL ldd_write: no write seen, want addr=%0d data=%h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL ldd_write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL ldd_extra: got %0d extra writes want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_wrap();
        wr_t e, o;
        send(4'd1, 8'(rows - 1));
        send(4'd2, 8'(cols - 2));
        send(4'd4, 8'h31);
        send(4'd4, 8'h52);
        send(4'd4, 8'h93);
        send(4'd3, 8'h07);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL ldi_write: no write seen, want addr=%0d data=%h", e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
                    n_fail++;
                    $display("FAIL ldi_write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                             o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL ldi_extra: got %0d extra writes want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_fill();
        int  t_first, k, bad, first_bad, n;
        wr_t e, o;
        send(4'd5, 8'hF7);
        send(4'd6, 8'h00);
        t_first = cyc;
        // instructions offered during the fill must be dropped
        inst = {4'd3, 8'h11};
        inst_en = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (obs_ready !== 1'b0 || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_busy: got ready=%b err=%b want ready=0 err=0", obs_ready, obs_err);
        end
        inst_en = 1'b0;
        k = 0;
        while (obs_ready !== 1'b1 && k < rows * cols + 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (obs_ready !== 1'b1 || cyc !== t_first + rows * cols || obs_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_done: got ready=%b at cyc=%0d we=%b want ready=1 at cyc=%0d we=0",
                     obs_ready, cyc, obs_we, t_first + rows * cols);
        end
        // cursor must be back at (0,0)
        send(4'd3, 8'h35);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL fill_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            e = exp_q[i];
            o = obs_q[i];
            if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            e = exp_q[first_bad];
            o = obs_q[first_bad];
            n_fail++;
            $display("FAIL fill_stream: %0d bad writes, first #%0d got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                     bad, first_bad, o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_error();
        test_reset();
        send(4'd2, 8'd200);
        n_checks++;
        if (obs_err !== 1'b1 || obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ldc_range_error: got err=%b ready=%b want err=1 ready=0", obs_err, obs_ready);
        end
        inst = {4'd3, 8'h05};
        inst_en = 1'b1;
        repeat (2) tick();
        idle(2);
        n_checks++;
        if (obs_q.size() != 0 || obs_err !== 1'b1 || obs_we !== 1'b0) begin
            n_fail++;
            $display("FAIL error_absorb: got writes=%0d err=%b we=%b want writes=0 err=1 we=0",
                     obs_q.size(), obs_err, obs_we);
        end
        test_reset();
        n_checks++;
        if (obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL error_cleared: got err=%b want 0", obs_err);
        end
        send(4'hF, 8'h00);
        idle(1);
        n_checks++;
        if (obs_err !== 1'b1 || obs_ready !== 1'b0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL opcode_f_error: got err=%b ready=%b writes=%0d want err=1 ready=0 writes=0",
                     obs_err, obs_ready, obs_q.size());
        end
        test_reset();
    endtask

    task automatic test_reset_mid_fill();
        int  k;
        wr_t o;
        test_reset();
        send(4'd6, 8'h00);
        inst_en = 1'b0;
        exp_q.delete();
        k = 0;
        while (!(obs_we === 1'b1 && obs_addr === 15'd100) && k < 300) begin
            tick();
            k++;
        end
        n_checks++;
        if (!(obs_we === 1'b1 && obs_addr === 15'd100)) begin
            n_fail++;
            $display("FAIL fill_reach_100: got we=%b addr=%0d want we=1 addr=100", obs_we, obs_addr);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (obs_we !== 1'b0 || obs_ready !== 1'b0 || obs_q.size() != 101) begin
            n_fail++;
            $display("FAIL fill_abort: got we=%b ready=%b writes=%0d want we=0 ready=0 writes=101",
                     obs_we, obs_ready, obs_q.size());
        end
        reset = 1'b0;
        m_row = 0; m_col = 0; m_fill = 8'h00;
        tick();
        obs_q.delete();
        n_checks++;
        if (obs_ready !== 1'b1 || obs_we !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_ready: got ready=%b we=%b want ready=1 we=0", obs_ready, obs_we);
        end
        send(4'd3, 8'h09);
        idle(3);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL restart_write: got %0d writes want 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            if (o.addr !== 15'd0 || o.data !== 8'h09 || o.cyc !== exp_q[0].cyc) begin
                n_fail++;
                $display("FAIL restart_write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=0 data=09",
                         o.cyc, o.addr, o.data, exp_q[0].cyc);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        for (int cfg = 0; cfg < 2; cfg++) begin
            sel   = cfg[0];
            cols  = (cfg == 0) ? 200 : 64;
            rows  = (cfg == 0) ? 150 : 48;
            cmask = (cfg == 0) ? 8'h0F : 8'hFF;
            test_reset();
            test_write();
            test_wrap();
            test_fill();
        end
        sel   = 1'b0;
        cols  = 200;
        rows  = 150;
        cmask = 8'h0F;
        test_error();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
